// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge filter: one output pixel per input pixel, zeroed borders,
// end-of-frame drain. Define SOBEL_THRESHOLD_EN to binarise interior results against THRESHOLD.
module sobel_stream #(
  parameter int IMG_WIDTH  = 720,
  parameter int IMG_HEIGHT = 540,
  parameter int DWIDTH     = 8,
  parameter int THRESHOLD  = 64
) (
  input  logic              clock,
  input  logic              reset,
  output logic              in_rd_en,
  input  logic [DWIDTH-1:0] in_dout,
  input  logic              in_empty,
  output logic              out_wr_en,
  output logic [DWIDTH-1:0] out_din,
  input  logic              out_full
);

  localparam int N     = IMG_WIDTH * IMG_HEIGHT;
  localparam int CW    = $clog2(N + 1);
  localparam int DEPTH = 2 * IMG_WIDTH + 3;
  localparam int AW    = DWIDTH + 4;
  localparam int GW    = DWIDTH + 5;

  typedef enum logic [1:0] {FILL, RUN, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     n, o, row, col;
  logic              shift, shift_zero, frame_done;
  logic [DWIDTH-1:0] line_buf [DEPTH];

  logic signed [AW-1:0] win [3][3];
  logic signed [AW-1:0] gx, gy;
  logic [GW-1:0]        g;
  logic [DWIDTH-1:0]    pix;
  logic                 border;

  function automatic logic [GW-1:0] abs_mag(input logic signed [AW-1:0] v);
    logic [AW-1:0] m;
    m = v[AW-1] ? AW'(-v) : AW'(v);
    return {1'b0, m};
  endfunction

  function automatic logic [DWIDTH-1:0] sat_pix(input logic [GW-1:0] v);
    return (|v[GW-1:DWIDTH]) ? {DWIDTH{1'b1}} : v[DWIDTH-1:0];
  endfunction

  always_comb begin
    state_nxt  = state;
    in_rd_en   = 1'b0;
    out_wr_en  = 1'b0;
    shift      = 1'b0;
    shift_zero = 1'b0;
    frame_done = 1'b0;
    if (!reset) begin
      unique case (state)
        FILL: if (!in_empty) begin
          in_rd_en = 1'b1;
          shift    = 1'b1;
          if (n == CW'(IMG_WIDTH + 1)) state_nxt = RUN;
        end
        RUN: if (!in_empty && !out_full) begin
          in_rd_en  = 1'b1;
          out_wr_en = 1'b1;
          shift     = 1'b1;
          if (n == CW'(N - 1)) state_nxt = DRAIN;
        end
        DRAIN: if (!out_full) begin
          out_wr_en  = 1'b1;
          shift      = 1'b1;
          shift_zero = 1'b1;
          if (o == CW'(N - 1)) begin
            state_nxt  = FILL;
            frame_done = 1'b1;
          end
        end
        default: state_nxt = FILL;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= FILL;
      n     <= '0;
      o     <= '0;
      row   <= '0;
      col   <= '0;
    end else begin
      state <= state_nxt;
      if (frame_done) begin
        n   <= '0;
        o   <= '0;
        row <= '0;
        col <= '0;
      end else begin
        if (in_rd_en) n <= n + 1'b1;
        if (out_wr_en) begin
          o <= o + 1'b1;
          if (col == CW'(IMG_WIDTH - 1)) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
      end
    end
  end

  // Index 0 holds the newest pixel; the oldest tap (2*W+2) is the window's top-left.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) line_buf[k] <= '0;
    end else if (shift) begin
      line_buf[0] <= shift_zero ? '0 : in_dout;
      for (int k = 1; k < DEPTH; k++) line_buf[k] <= line_buf[k-1];
    end
  end

  always_comb begin
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        win[dr][dc] = $signed({4'b0000, line_buf[(2 - dr) * IMG_WIDTH + (2 - dc)]});
    gx = (win[0][2] + win[1][2] + win[1][2] + win[2][2])
       - (win[0][0] + win[1][0] + win[1][0] + win[2][0]);
    gy = (win[2][0] + win[2][1] + win[2][1] + win[2][2])
       - (win[0][0] + win[0][1] + win[0][1] + win[0][2]);
    g  = abs_mag(gx) + abs_mag(gy);
`ifdef SOBEL_THRESHOLD_EN
    pix = (g >= GW'(THRESHOLD)) ? {DWIDTH{1'b1}} : '0;
`else
    pix = sat_pix(g);
`endif
    border  = (row == '0) || (row == CW'(IMG_HEIGHT - 1)) ||
              (col == '0) || (col == CW'(IMG_WIDTH - 1));
    out_din = (out_wr_en && !border) ? pix : '0;
  end

endmodule

// File: doc/sobel_stream.md
Name: sobel_stream

Overview:
- Parametrised streaming 3x3 Sobel edge filter. Sits between an input pixel FIFO and an output pixel FIFO in the image pipeline.
- Emits exactly one output pixel per input pixel: a full IMG_WIDTH x IMG_HEIGHT frame, with border pixels forced to zero.
- Adds three things over a plain Sobel stage: a generic pixel width, an end-of-frame drain (so the last rows are flushed without further input), and back-to-back frames.

Parameters:
- IMG_WIDTH, 720, pixels per row (>=4).
- IMG_HEIGHT, 540, rows per frame (>=3).
- DWIDTH, 8, pixel width in bits for input and output.
- THRESHOLD, 64, binarisation threshold; only used when SOBEL_THRESHOLD_EN is defined.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_rd_en  out  1  pop request to input FIFO.
- in_dout  in  DWIDTH  input pixel, raster order; valid in the cycle in_rd_en=1.
- in_empty  in  1  input FIFO empty.
- out_wr_en  out  1  push request to output FIFO.
- out_din  out  DWIDTH  output pixel; valid in the cycle out_wr_en=1.
- out_full  in  1  output FIFO full.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. When reset=1 at a rising edge:
  - state returns to FILL;
  - pixel counter n, output counter o, row and column counters all clear to 0;
  - line buffer clears to 0.
  - in_rd_en and out_wr_en are combinational from registered state and inputs, so both are 0 while reset is asserted. out_din is 0 whenever out_wr_en=0.
- Storage: line buffer is a shift register of depth 2*IMG_WIDTH+3 DWIDTH-bit entries. The 3x3 window taps it at offsets i*IMG_WIDTH+j, for i,j in 0..2.
- Frame size: N = IMG_WIDTH*IMG_HEIGHT. Counters are sized with $clog2(N+1).
- FILL state:
  - in_rd_en = !in_empty; shift in_dout into the buffer; n++.
  - No writes in this state.
  - When n reaches IMG_WIDTH+2, go to RUN.
- RUN state:
  - A transfer fires iff !in_empty && !out_full. In that cycle in_rd_en=1 and out_wr_en=1 together.
  - out_din = result for output pixel o, computed combinationally from the current window, i.e. before the shift.
  - The buffer shifts in in_dout; n++, o++.
  - When n==N after the transfer, go to DRAIN.
- DRAIN state:
  - in_rd_en=0. A transfer fires iff !out_full: out_wr_en=1, shift in 0, o++.
  - After output o==N-1 is written, go to FILL with all counters cleared. The next frame starts immediately.
  - DRAIN emits exactly IMG_WIDTH+2 outputs. Total outputs per frame = N.
- Stalls: if either side blocks in RUN, nothing moves (no read, no write, no shift). Stalls of any length are lossless. Throughput is 1 pixel/cycle when unblocked.
- Latency: the first output is written in the first RUN transfer, i.e. after IMG_WIDTH+2 pixels have been read.
- Border rule: output pixel (r,c) with r==0, r==IMG_HEIGHT-1, c==0 or c==IMG_WIDTH-1 → out_din=0. This also masks window wrap across row and frame boundaries.
- Interior arithmetic:
  - Gx = [-1 0 1; -2 0 2; -1 0 1], Gy = [-1 -2 -1; 0 0 0; 1 2 1], with the window's top-left at pixel (r-1,c-1).
  - Signed, DWIDTH+4 bits.
  - G = |Gx| + |Gy| in DWIDTH+5 bits, saturated to 2^DWIDTH-1.
- Simultaneous conditions:
  - in_empty and out_full both high in RUN → stall.
  - out_full high in DRAIN → hold.
  - Reset overrides everything, including mid-frame and mid-drain. Partial frames are discarded.

Optional Feature:
- Macro: SOBEL_THRESHOLD_EN.
- Defined: interior out_din = (G >= THRESHOLD) ? 2^DWIDTH-1 : 0. Borders stay 0.
- Undefined: out_din is the saturated G; THRESHOLD is ignored.
- Timing and handshakes are identical in both builds.

Test Plan (IMG_WIDTH=8, IMG_HEIGHT=6, DWIDTH=8, N=48; feature off unless stated):
- Uniform frame, all 100, in_empty=0, out_full=0 → 48 writes, all 0. First write in the cycle after the 10th read. Last 10 writes occur with in_rd_en=0.
- Vertical step, columns 0-3 =0 and columns 4-7 =200 → interior (r,3) and (r,4) = 255 (|Gx|=800, saturated). All other pixels 0.
- Single pixel 10 at (2,2), rest 0 → (2,1)=20, (1,1)=20, (3,3)=20, (2,3)=20, (2,2)=0, (5,x)=0.
- out_full held high for 20 cycles mid-RUN → in_rd_en=0 and out_wr_en=0 throughout. The output stream is identical to the unstalled run.
- Random in_empty gaps plus two back-to-back frames → 96 outputs total, each frame matching the golden model. The second frame is unaffected by the first.
- Reset asserted for 1 cycle after 20 reads, then a fresh uniform-100 frame → no stale writes; 48 zero outputs. Additionally, with SOBEL_THRESHOLD_EN and THRESHOLD=64, the step frame gives 255 on edges and 0 elsewhere.
